// File: rtl/fetch_stage_if.sv
// Instruction-memory request bus between the fetch stage (master) and memory (slave).
interface fetch_stage_if;
  logic        imem_rd;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_done;

  modport master (output imem_rd, output imem_addr, input imem_rdata, input imem_done);
  modport slave  (input imem_rd, input imem_addr, output imem_rdata, output imem_done);
endinterface

// File: rtl/fetch_stage.sv
// WISC-SP22 instruction fetch stage with IF/ID register: hold-until-done imem handshake,
// one-entry stall buffer, wrong-path drain on redirect, and HALT stop.
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect,
  input  logic [15:0]        redirect_pc,
  fetch_stage_if.master      imem,
  output logic [15:0]        Instruction_ID,
  output logic [15:0]        PC_plus2_ID,
  output logic               valid_ID,
  output logic               fetch_halted
);
  localparam int unsigned XLEN = 16;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_FULL   = 2'd1,
    ST_HALTED = 2'd2,
    ST_DRAIN  = 2'd3
  } state_e;

  state_e          state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] drain_addr_q;
  logic [XLEN-1:0] buf_instr_q;
  logic [XLEN-1:0] buf_pc2_q;
  logic            buf_full_q;
  logic [XLEN-1:0] instr_id_q;
  logic [XLEN-1:0] pc2_id_q;
  logic            valid_id_q;

  logic            rd_c;
  logic            accept_c;
  logic            is_halt_c;
  logic [XLEN-1:0] pc_inc_c;

  // Request is gated by reset so memory never sees a fetch while rst_n is low.
  assign rd_c      = rst_n && ((state_q == ST_FETCH) || (state_q == ST_DRAIN));
  assign accept_c  = rd_c && imem.imem_done;
  assign pc_inc_c  = pc_q + XLEN'(2);
  assign is_halt_c = (imem.imem_rdata[15:11] == 5'b00000);

  assign imem.imem_rd   = rd_c;
  assign imem.imem_addr = (state_q == ST_DRAIN) ? drain_addr_q : pc_q;

  assign Instruction_ID = instr_id_q;
  assign PC_plus2_ID    = pc2_id_q;
  assign valid_ID       = valid_id_q;
  assign fetch_halted   = (state_q == ST_HALTED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_FETCH;
      pc_q         <= RESET_PC;
      drain_addr_q <= '0;
      buf_instr_q  <= '0;
      buf_pc2_q    <= '0;
      buf_full_q   <= 1'b0;
      instr_id_q   <= NOP_INSTR;
      pc2_id_q     <= '0;
      valid_id_q   <= 1'b0;
    end else if (redirect) begin
      // An un-accepted request must finish at its original address before refetching.
      instr_id_q <= NOP_INSTR;
      valid_id_q <= 1'b0;
      buf_full_q <= 1'b0;
      pc_q       <= redirect_pc;
      if ((state_q == ST_FETCH) && !accept_c) begin
        drain_addr_q <= pc_q;
        state_q      <= ST_DRAIN;
      end else if ((state_q == ST_DRAIN) && !accept_c) begin
        state_q <= ST_DRAIN;
      end else begin
        state_q <= ST_FETCH;
      end
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (accept_c) begin
            pc_q <= pc_inc_c;
            if (!stall) begin
              instr_id_q <= imem.imem_rdata;
              pc2_id_q   <= pc_inc_c;
              valid_id_q <= 1'b1;
              state_q    <= is_halt_c ? ST_HALTED : ST_FETCH;
            end else begin
              buf_instr_q <= imem.imem_rdata;
              buf_pc2_q   <= pc_inc_c;
              buf_full_q  <= 1'b1;
              state_q     <= is_halt_c ? ST_HALTED : ST_FULL;
            end
          end else if (!stall) begin
            instr_id_q <= NOP_INSTR;
            valid_id_q <= 1'b0;
          end
        end
        ST_FULL: begin
          if (!stall) begin
            instr_id_q <= buf_instr_q;
            pc2_id_q   <= buf_pc2_q;
            valid_id_q <= 1'b1;
            buf_full_q <= 1'b0;
            state_q    <= ST_FETCH;
          end
        end
        ST_HALTED: begin
          // A HALT caught under stall waits here in the buffer until decode frees up.
          if (!stall) begin
            if (buf_full_q) begin
              instr_id_q <= buf_instr_q;
              pc2_id_q   <= buf_pc2_q;
              valid_id_q <= 1'b1;
              buf_full_q <= 1'b0;
            end else begin
              instr_id_q <= NOP_INSTR;
              valid_id_q <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          if (accept_c) begin
            state_q <= ST_FETCH;
          end
          if (!stall) begin
            instr_id_q <= NOP_INSTR;
            valid_id_q <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: wait-state memory model plus an expected-instruction scoreboard.
module tb_fetch_stage;
  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc2;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] Instruction_ID;
  logic [15:0] PC_plus2_ID;
  logic        valid_ID;
  logic        fetch_halted;

  fetch_stage_if bus ();

  fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem           (bus),
    .Instruction_ID (Instruction_ID),
    .PC_plus2_ID    (PC_plus2_ID),
    .valid_ID       (valid_ID),
    .fetch_halted   (fetch_halted)
  );

  logic [15:0] mem [0:32767];
  int          waits;
  int          wcnt;
  exp_t        sb[$];
  int          n_vec;
  int          n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: done after 'waits' cycles of a held request; counter restarts per request.
  assign bus.imem_rdata = mem[bus.imem_addr[15:1]];
  assign bus.imem_done  = bus.imem_rd && (wcnt == waits);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             wcnt <= 0;
    else if (!bus.imem_rd || bus.imem_done) wcnt <= 0;
    else                                    wcnt <= wcnt + 1;
  end

  task automatic load4(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c, input logic [15:0] d);
    for (int i = 0; i < 32768; i++) mem[i] = 16'h4000;
    mem[0] = a; mem[1] = b; mem[2] = c; mem[3] = d;
  endtask

  task automatic push(input logic [15:0] instr, input logic [15:0] pc2);
    exp_t e;
    e.instr = instr;
    e.pc2   = pc2;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    sb.delete();
    #2 rst_n = 1'b1;
  endtask

  // One clock; any freshly loaded valid instruction is scored against the queue head.
  task automatic tick();
    logic st;
    exp_t e;
    @(posedge clk);
    st = stall;
    #1;
    if (!st && valid_ID) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got %h/%h, want none", Instruction_ID, PC_plus2_ID);
      end else begin
        e = sb.pop_front();
        if ({Instruction_ID, PC_plus2_ID} !== {e.instr, e.pc2}) begin
          n_err++;
          $display("FAIL sb_instr: got %h/%h, want %h/%h", Instruction_ID, PC_plus2_ID, e.instr, e.pc2);
        end
      end
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_vec++; if (bus.imem_rd !== 1'b0)          begin n_err++; $display("FAIL rst_rd: got %b want 0", bus.imem_rd); end
    n_vec++; if (Instruction_ID !== 16'h0800)   begin n_err++; $display("FAIL rst_instr: got %h want 0800", Instruction_ID); end
    n_vec++; if (PC_plus2_ID !== 16'h0000)      begin n_err++; $display("FAIL rst_pc2: got %h want 0000", PC_plus2_ID); end
    n_vec++; if (valid_ID !== 1'b0)             begin n_err++; $display("FAIL rst_valid: got %b want 0", valid_ID); end
    n_vec++; if (fetch_halted !== 1'b0)         begin n_err++; $display("FAIL rst_halted: got %b want 0", fetch_halted); end
    rst_n = 1'b1;
    #1;
    n_vec++; if (bus.imem_rd !== 1'b1)          begin n_err++; $display("FAIL rst_rel_rd: got %b want 1", bus.imem_rd); end
    n_vec++; if (bus.imem_addr !== 16'h0000)    begin n_err++; $display("FAIL rst_rel_addr: got %h want 0000", bus.imem_addr); end
  endtask

  task automatic test_zero_wait();
    load4(16'h4001, 16'h4102, 16'h4203, 16'h0000);
    waits = 0;
    do_reset();
    push(16'h4001, 16'h0002); push(16'h4102, 16'h0004);
    push(16'h4203, 16'h0006); push(16'h0000, 16'h0008);
    for (int i = 0; i < 4; i++) tick();
    n_vec++; if (fetch_halted !== 1'b1)         begin n_err++; $display("FAIL zw_halted: got %b want 1", fetch_halted); end
    n_vec++; if (bus.imem_rd !== 1'b0)          begin n_err++; $display("FAIL zw_rd: got %b want 0", bus.imem_rd); end
    tick(); tick();
    n_vec++; if (valid_ID !== 1'b0 || Instruction_ID !== 16'h0800)
      begin n_err++; $display("FAIL zw_bubble: got %b/%h want 0/0800", valid_ID, Instruction_ID); end
    n_vec++; if (bus.imem_rd !== 1'b0 || fetch_halted !== 1'b1)
      begin n_err++; $display("FAIL zw_stay_halted: got rd %b halted %b want 0/1", bus.imem_rd, fetch_halted); end
    n_vec++; if (sb.size() != 0)                begin n_err++; $display("FAIL zw_sb_left: got %0d want 0", sb.size()); end
  endtask

  task automatic test_wait_states();
    load4(16'h4001, 16'h4102, 16'h0000, 16'h4000);
    waits = 2;
    do_reset();
    push(16'h4001, 16'h0002); push(16'h4102, 16'h0004); push(16'h0000, 16'h0006);
    for (int cyc = 0; cyc < 9; cyc++) begin
      logic [15:0] ea;
      ea = 16'(2 * (cyc / 3));
      n_vec++; if (bus.imem_addr !== ea)        begin n_err++; $display("FAIL ws_addr c%0d: got %h want %h", cyc, bus.imem_addr, ea); end
      if (cyc >= 3 && (cyc % 3) != 0) begin
        n_vec++; if (valid_ID !== 1'b0 || Instruction_ID !== 16'h0800)
          begin n_err++; $display("FAIL ws_bubble c%0d: got %b/%h want 0/0800", cyc, valid_ID, Instruction_ID); end
      end
      tick();
    end
    n_vec++; if (fetch_halted !== 1'b1)         begin n_err++; $display("FAIL ws_halted: got %b want 1", fetch_halted); end
    n_vec++; if (sb.size() != 0)                begin n_err++; $display("FAIL ws_sb_left: got %0d want 0", sb.size()); end
  endtask

  task automatic test_stall();
    load4(16'h4001, 16'h4102, 16'h4203, 16'h0000);
    waits = 0;
    do_reset();
    push(16'h4001, 16'h0002); push(16'h4102, 16'h0004);
    push(16'h4203, 16'h0006); push(16'h0000, 16'h0008);
    tick();
    stall = 1'b1;
    tick();
    n_vec++; if (bus.imem_rd !== 1'b0)          begin n_err++; $display("FAIL st_full_rd: got %b want 0", bus.imem_rd); end
    n_vec++; if (Instruction_ID !== 16'h4001 || valid_ID !== 1'b1)
      begin n_err++; $display("FAIL st_hold: got %h/%b want 4001/1", Instruction_ID, valid_ID); end
    tick(); tick();
    n_vec++; if (Instruction_ID !== 16'h4001)   begin n_err++; $display("FAIL st_hold2: got %h want 4001", Instruction_ID); end
    stall = 1'b0;
    tick();
    n_vec++; if (Instruction_ID !== 16'h4102)   begin n_err++; $display("FAIL st_release: got %h want 4102", Instruction_ID); end
    n_vec++; if (bus.imem_addr !== 16'h0004 || bus.imem_rd !== 1'b1)
      begin n_err++; $display("FAIL st_refetch: got %h/%b want 0004/1", bus.imem_addr, bus.imem_rd); end
    tick(); tick();
    n_vec++; if (sb.size() != 0)                begin n_err++; $display("FAIL st_sb_left: got %0d want 0", sb.size()); end
  endtask

  task automatic test_redirect_drain();
    load4(16'h4001, 16'h4102, 16'h4000, 16'h4000);
    mem[16'h20] = 16'h4a0a;
    mem[16'h21] = 16'h0000;
    waits = 2;
    do_reset();
    push(16'h4001, 16'h0002); push(16'h4a0a, 16'h0042); push(16'h0000, 16'h0044);
    tick(); tick(); tick();
    redirect = 1'b1; redirect_pc = 16'h0040;
    n_vec++; if (bus.imem_addr !== 16'h0002)    begin n_err++; $display("FAIL rd_addr_c3: got %h want 0002", bus.imem_addr); end
    tick();
    redirect = 1'b0;
    for (int c = 4; c < 6; c++) begin
      n_vec++; if (bus.imem_addr !== 16'h0002 || bus.imem_rd !== 1'b1)
        begin n_err++; $display("FAIL rd_drain_addr c%0d: got %h/%b want 0002/1", c, bus.imem_addr, bus.imem_rd); end
      n_vec++; if (valid_ID !== 1'b0)           begin n_err++; $display("FAIL rd_drain_valid c%0d: got %b want 0", c, valid_ID); end
      tick();
    end
    n_vec++; if (bus.imem_addr !== 16'h0040 || bus.imem_rd !== 1'b1)
      begin n_err++; $display("FAIL rd_target: got %h/%b want 0040/1", bus.imem_addr, bus.imem_rd); end
    n_vec++; if (valid_ID !== 1'b0)             begin n_err++; $display("FAIL rd_discard: got %b want 0", valid_ID); end
    for (int i = 0; i < 6; i++) tick();
    n_vec++; if (fetch_halted !== 1'b1)         begin n_err++; $display("FAIL rd_halted: got %b want 1", fetch_halted); end
    n_vec++; if (sb.size() != 0)                begin n_err++; $display("FAIL rd_sb_left: got %0d want 0", sb.size()); end
  endtask

  task automatic test_redirect_halted();
    waits = 0;
    mem[8] = 16'h4303;
    mem[9] = 16'h0000;
    n_vec++; if (fetch_halted !== 1'b1)         begin n_err++; $display("FAIL rh_pre: got %b want 1", fetch_halted); end
    redirect = 1'b1; redirect_pc = 16'h0010;
    push(16'h4303, 16'h0012); push(16'h0000, 16'h0014);
    tick();
    redirect = 1'b0;
    n_vec++; if (bus.imem_addr !== 16'h0010 || bus.imem_rd !== 1'b1)
      begin n_err++; $display("FAIL rh_addr: got %h/%b want 0010/1", bus.imem_addr, bus.imem_rd); end
    n_vec++; if (fetch_halted !== 1'b0)         begin n_err++; $display("FAIL rh_resume: got %b want 0", fetch_halted); end
    tick(); tick();
    n_vec++; if (sb.size() != 0 || fetch_halted !== 1'b1)
      begin n_err++; $display("FAIL rh_end: got sb %0d halted %b want 0/1", sb.size(), fetch_halted); end
  endtask

  task automatic test_redirect_full();
    load4(16'h4001, 16'h4102, 16'h4203, 16'h0000);
    waits = 0;
    do_reset();
    push(16'h4001, 16'h0002); push(16'h0000, 16'h0008);
    tick();
    stall = 1'b1;
    tick();
    redirect = 1'b1; redirect_pc = 16'h0006;
    tick();
    redirect = 1'b0; stall = 1'b0;
    n_vec++; if (valid_ID !== 1'b0 || Instruction_ID !== 16'h0800)
      begin n_err++; $display("FAIL rf_bubble: got %b/%h want 0/0800", valid_ID, Instruction_ID); end
    n_vec++; if (bus.imem_addr !== 16'h0006 || bus.imem_rd !== 1'b1)
      begin n_err++; $display("FAIL rf_addr: got %h/%b want 0006/1", bus.imem_addr, bus.imem_rd); end
    tick(); tick();
    n_vec++; if (sb.size() != 0)                begin n_err++; $display("FAIL rf_sb_left: got %0d want 0", sb.size()); end
  endtask

  task automatic test_wrap();
    load4(16'h4001, 16'h0000, 16'h4000, 16'h4000);
    mem[16'h7FFF] = 16'h4777;
    waits = 0;
    do_reset();
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    tick();
    redirect = 1'b0;
    n_vec++; if (valid_ID !== 1'b0 || bus.imem_addr !== 16'hFFFE)
      begin n_err++; $display("FAIL wr_start: got %b/%h want 0/fffe", valid_ID, bus.imem_addr); end
    push(16'h4777, 16'h0000); push(16'h4001, 16'h0002); push(16'h0000, 16'h0004);
    tick();
    n_vec++; if (PC_plus2_ID !== 16'h0000 || bus.imem_addr !== 16'h0000)
      begin n_err++; $display("FAIL wr_wrap: got pc2 %h addr %h want 0000/0000", PC_plus2_ID, bus.imem_addr); end
    tick(); tick();
    n_vec++; if (sb.size() != 0)                begin n_err++; $display("FAIL wr_sb_left: got %0d want 0", sb.size()); end
  endtask

  task automatic test_reset_mid();
    load4(16'h4001, 16'h4102, 16'h4203, 16'h0000);
    mem[16'h7FFF] = 16'h4777;
    waits = 0;
    do_reset();
    push(16'h4001, 16'h0002); push(16'h4102, 16'h0004);
    tick(); tick();
    rst_n = 1'b0;
    #1;
    n_vec++; if (valid_ID !== 1'b0 || Instruction_ID !== 16'h0800 || PC_plus2_ID !== 16'h0000)
      begin n_err++; $display("FAIL rm_stream: got %b/%h/%h want 0/0800/0000", valid_ID, Instruction_ID, PC_plus2_ID); end
    n_vec++; if (bus.imem_rd !== 1'b0)          begin n_err++; $display("FAIL rm_stream_rd: got %b want 0", bus.imem_rd); end
    sb.delete();
    waits = 2;
    rst_n = 1'b1;
    #1;
    n_vec++; if (bus.imem_addr !== 16'h0000)    begin n_err++; $display("FAIL rm_restart: got %h want 0000", bus.imem_addr); end
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    tick();
    redirect = 1'b0;
    n_vec++; if (bus.imem_addr !== 16'h0000)    begin n_err++; $display("FAIL rm_drain: got %h want 0000", bus.imem_addr); end
    tick(); tick();
    n_vec++; if (bus.imem_addr !== 16'hFFFE || bus.imem_rd !== 1'b1)
      begin n_err++; $display("FAIL rm_fffe: got %h/%b want fffe/1", bus.imem_addr, bus.imem_rd); end
    tick();
    rst_n = 1'b0;
    #1;
    n_vec++; if (bus.imem_rd !== 1'b0 || fetch_halted !== 1'b0)
      begin n_err++; $display("FAIL rm_req_drop: got rd %b halted %b want 0/0", bus.imem_rd, fetch_halted); end
    n_vec++; if (valid_ID !== 1'b0 || Instruction_ID !== 16'h0800 || PC_plus2_ID !== 16'h0000)
      begin n_err++; $display("FAIL rm_req_id: got %b/%h/%h want 0/0800/0000", valid_ID, Instruction_ID, PC_plus2_ID); end
    rst_n = 1'b1;
    #1;
    n_vec++; if (bus.imem_addr !== 16'h0000)    begin n_err++; $display("FAIL rm_req_pc: got %h want 0000", bus.imem_addr); end
    push(16'h4001, 16'h0002);
    tick(); tick(); tick();
    n_vec++; if (sb.size() != 0)                begin n_err++; $display("FAIL rm_sb_left: got %0d want 0", sb.size()); end
  endtask

  initial begin
    n_vec       = 0;
    n_err       = 0;
    waits       = 0;
    rst_n       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    load4(16'h4001, 16'h4102, 16'h4203, 16'h0000);
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_stall();
    test_redirect_drain();
    test_redirect_halted();
    test_redirect_full();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
